// File: rtl/count_sequencer.sv
// Command front-end for an external 8-bit up/down loadable counter: preloads a
// start value, counts the requested number of steps, then reports result/wrap.
module count_sequencer #(
  parameter int N = 8,
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_start,
  input  logic         cmd_dir,
  input  logic [M-1:0] cmd_steps,
  input  logic         hold,
  output logic         cnt_load,
  output logic [N-1:0] cnt_in,
  output logic         cnt_din,
  output logic         cnt_en,
  input  logic [N-1:0] cnt_q,
  input  logic         cnt_cout,
  output logic         done,
  output logic [N-1:0] done_q,
  output logic         wrapped
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t       state, state_next;
  logic [N-1:0] start_r;
  logic         dir_r;
  logic [M-1:0] remaining;
  logic         wrap_r;

  assign cnt_in  = start_r;
  assign cnt_din = dir_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = LOAD;
      end
      LOAD: begin
        cnt_load   = 1'b1;
        state_next = (remaining != '0) ? RUN : DONE;
      end
      RUN: begin
        cnt_en = !hold;
        if (cnt_en && remaining == M'(1)) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // done is a single-cycle pulse; done_q and wrapped hold until the next run ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r   <= '0;
      dir_r     <= 1'b0;
      remaining <= '0;
      wrap_r    <= 1'b0;
      done      <= 1'b0;
      done_q    <= '0;
      wrapped   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            start_r   <= cmd_start;
            dir_r     <= cmd_dir;
            remaining <= cmd_steps;
            wrap_r    <= 1'b0;
          end
        end
        RUN: begin
          if (cnt_en) begin
            remaining <= remaining - M'(1);
            wrap_r    <= wrap_r | cnt_cout;
          end
        end
        DONE: begin
          done    <= 1'b1;
          done_q  <= cnt_q;
          wrapped <= wrap_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer, with a behavioural model of the
// external up/down loadable counter closing the loop.
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_start = '0;
  logic       cmd_dir = 1'b0;
  logic [7:0] cmd_steps = '0;
  logic       hold = 1'b0;
  logic       cnt_load;
  logic [7:0] cnt_in;
  logic       cnt_din;
  logic       cnt_en;
  logic [7:0] cnt_q = 8'h00;
  logic       cnt_cout;
  logic       done;
  logic [7:0] done_q;
  logic       wrapped;

  int n_checks = 0;
  int n_fail   = 0;

  count_sequencer #(.N(8), .M(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
    .hold(hold),
    .cnt_load(cnt_load), .cnt_in(cnt_in), .cnt_din(cnt_din), .cnt_en(cnt_en),
    .cnt_q(cnt_q), .cnt_cout(cnt_cout),
    .done(done), .done_q(done_q), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  // External counter: synchronous load, enable-gated count, carry/borrow from En
  always @(posedge clk) begin
    if (cnt_load)    cnt_q <= cnt_in;
    else if (cnt_en) cnt_q <= cnt_din ? cnt_q + 8'd1 : cnt_q - 8'd1;
  end
  assign cnt_cout = cnt_en && (cnt_din ? (cnt_q == 8'hFF) : (cnt_q == 8'h00));

  typedef struct {
    logic [7:0] start;
    logic       dir;
    logic [7:0] steps;
    logic [7:0] exp_q;
    logic       exp_wrap;
    int         exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents a command in the current (mid-)cycle and follows the run to done.
  task automatic run_cmd(input string tag, input logic [7:0] start, input logic dir,
                         input logic [7:0] steps, input int hold_from, input int hold_len,
                         input bit busy_pulses, input logic [7:0] exp_q,
                         input logic exp_wrap, input int exp_lat);
    int  lat = -1;
    int  loads = 0;
    int  ens = 0;
    bit  ready_bad = 0;
    bit  drive_bad = 0;
    check({tag, "_ready_at_cmd"}, cmd_ready, 1'b1);
    cmd_start = start;
    cmd_dir   = dir;
    cmd_steps = steps;
    cmd_valid = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      hold      = (hold_len > 0) && (cyc >= hold_from) && (cyc < hold_from + hold_len);
      cmd_valid = busy_pulses && (cyc % 2 == 1) && (cyc < exp_lat);
      #1;
      if (cnt_load) loads++;
      if (cnt_en) ens++;
      if (cnt_in !== start || cnt_din !== dir) drive_bad = 1;
      if (done === 1'b1) begin
        lat = cyc;
        cmd_valid = 1'b0;
        hold = 1'b0;
        break;
      end
      if (cmd_ready !== 1'b0) ready_bad = 1;
    end
    cmd_valid = 1'b0;
    hold = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_done_q"}, done_q, exp_q);
    check({tag, "_wrapped"}, wrapped, exp_wrap);
    check({tag, "_load_cycles"}, loads, 1);
    check({tag, "_en_cycles"}, ens, steps);
    check({tag, "_busy_ready_low"}, ready_bad, 1'b0);
    check({tag, "_cnt_drive"}, drive_bad, 1'b0);
  endtask

  task automatic applyStimulus();
    bit done_seen;
    bit ready_bad;

    vecs[0] = '{8'h10, 1'b1, 8'd5,   8'h15, 1'b0, 8};
    vecs[1] = '{8'hFE, 1'b1, 8'd4,   8'h02, 1'b1, 7};
    vecs[2] = '{8'h03, 1'b0, 8'd5,   8'hFE, 1'b1, 8};
    vecs[3] = '{8'h80, 1'b0, 8'd1,   8'h7F, 1'b0, 4};
    vecs[4] = '{8'hFF, 1'b1, 8'd1,   8'h00, 1'b1, 4};
    vecs[5] = '{8'h00, 1'b0, 8'd255, 8'h01, 1'b1, 258};
    vecs[6] = '{8'h7E, 1'b1, 8'd2,   8'h80, 1'b0, 5};

    #2 rst_n = 1'b0;
    #1;
    check("reset_cnt_load", cnt_load, 1'b0);
    check("reset_cnt_en", cnt_en, 1'b0);
    check("reset_cnt_in", cnt_in, 8'h00);
    check("reset_cnt_din", cnt_din, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_done_q", done_q, 8'h00);
    check("reset_wrapped", wrapped, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 7; i++) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].start, vecs[i].dir, vecs[i].steps,
              0, 0, 1'b0, vecs[i].exp_q, vecs[i].exp_wrap, vecs[i].exp_lat);
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_pulse_clear", i), done, 1'b0);
      check($sformatf("vec%0d_done_q_held", i), done_q, vecs[i].exp_q);
    end

    // Zero steps, then a second command presented during the done cycle
    run_cmd("zero", 8'hA5, 1'b1, 8'd0, 0, 0, 1'b0, 8'hA5, 1'b0, 3);
    run_cmd("b2b", 8'h10, 1'b0, 8'd3, 0, 0, 1'b0, 8'h0D, 1'b0, 6);
    @(negedge clk);
    #1;

    // Hold for 3 RUN cycles, with ignored command pulses while busy
    run_cmd("hold", 8'h00, 1'b1, 8'd4, 3, 3, 1'b1, 8'h04, 1'b0, 10);
    @(negedge clk);
    #1;

    // Reset during the second RUN cycle abandons the run
    cmd_start = 8'h50; cmd_dir = 1'b1; cmd_steps = 8'd6; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("midrun_en_before_reset", cnt_en, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrun_cnt_en", cnt_en, 1'b0);
    check("midrun_cnt_load", cnt_load, 1'b0);
    check("midrun_done", done, 1'b0);
    check("midrun_done_q", done_q, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    ready_bad = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (done === 1'b1) done_seen = 1;
      if (cmd_ready !== 1'b1) ready_bad = 1;
      @(negedge clk);
    end
    #1;
    check("midrun_no_done", done_seen, 1'b0);
    check("midrun_ready_after", ready_bad, 1'b0);
    run_cmd("after_reset", 8'h20, 1'b1, 8'd2, 0, 0, 1'b0, 8'h22, 1'b0, 5);
  endtask

  task automatic checkOutput();
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    applyStimulus();
    checkOutput();
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got timeout, expected test completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
